// File: rtl/friscv_mem_arbiter_if.sv
// Request/response bundle between NB_CH requesters, the arbiter and one shared memory port.
// Pure wiring with no latency. Backpressure is the en/ready handshake: req_en holds until req_ready.
// slave = arbiter view, master = requesters plus memory view.
interface friscv_mem_arbiter_if #(
    parameter int NB_CH = 2,
    parameter int ADDRW = 16,
    parameter int XLEN  = 32
);
    logic [NB_CH-1:0]          req_en;
    logic [NB_CH-1:0]          req_wr;
    logic [NB_CH*ADDRW-1:0]    req_addr;
    logic [NB_CH*XLEN-1:0]     req_wdata;
    logic [NB_CH*XLEN/8-1:0]   req_strb;
    logic [XLEN-1:0]           req_rdata;
    logic [NB_CH-1:0]          req_ready;
    logic [NB_CH-1:0]          arb_grant;
    logic                      mem_en;
    logic                      mem_wr;
    logic [ADDRW-1:0]          mem_addr;
    logic [XLEN-1:0]           mem_wdata;
    logic [XLEN/8-1:0]         mem_strb;
    logic [XLEN-1:0]           mem_rdata;
    logic                      mem_ready;

    modport slave (
        input  req_en, req_wr, req_addr, req_wdata, req_strb, mem_rdata, mem_ready,
        output req_rdata, req_ready, arb_grant, mem_en, mem_wr, mem_addr, mem_wdata, mem_strb
    );

    modport master (
        output req_en, req_wr, req_addr, req_wdata, req_strb, mem_rdata, mem_ready,
        input  req_rdata, req_ready, arb_grant, mem_en, mem_wr, mem_addr, mem_wdata, mem_strb
    );
endinterface

// File: rtl/friscv_mem_arbiter.sv
// N-channel round-robin / fixed-priority arbiter merging requesters onto one memory port.
// Latency: 1 cycle from req_en (IDLE) to mem_en; back-to-back grants keep mem_en high.
// Backpressure: mem_ready low holds the grant and payload; waiting channels keep req_en up.
module friscv_mem_arbiter #(
    parameter int NB_CH      = 2,
    parameter int ADDRW      = 16,
    parameter int XLEN       = 32,
    parameter int FIXED_PRIO = 0
) (
    input logic                 aclk,
    input logic                 aresetn,
    input logic                 srst,
    friscv_mem_arbiter_if.slave bus
);
    localparam int IW = $clog2(NB_CH);
    localparam int SW = XLEN / 8;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]       state;
    logic [IW-1:0]    gnt;
    logic [IW-1:0]    last;
    logic [IW-1:0]    base;
    logic [NB_CH-1:0] req_mask;
    logic [NB_CH-1:0] gnt_oh;
    logic             win_vld;
    logic [IW-1:0]    win_idx;
    logic             busy;
    logic             done;
    int               scan_ch;

    assign busy   = (state == BUSY);
    assign done   = busy && bus.mem_ready && !srst;
    assign gnt_oh = NB_CH'(1) << gnt;

    // On completion the served channel still shows req_en, so it is masked and the
    // scan starts after it (the value `last` is about to take).
    always_comb begin
        req_mask = bus.req_en;
        if (busy) req_mask[gnt] = 1'b0;
        base    = busy ? gnt : last;
        win_vld = 1'b0;
        win_idx = '0;
        scan_ch = 0;
        for (int k = 1; k <= NB_CH; k++) begin
            scan_ch = (FIXED_PRIO != 0) ? (k - 1) : ((int'(base) + k) % NB_CH);
            if (!win_vld && req_mask[scan_ch[IW-1:0]]) begin
                win_vld = 1'b1;
                win_idx = scan_ch[IW-1:0];
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= IW'(NB_CH - 1);
        end else if (srst) begin
            state <= IDLE;
            gnt   <= '0;
            last  <= IW'(NB_CH - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (win_vld) begin
                        gnt   <= win_idx;
                        state <= BUSY;
                    end
                end
                default: begin
                    if (bus.mem_ready) begin
                        last <= gnt;
                        if (win_vld) gnt   <= win_idx;
                        else         state <= IDLE;
                    end
                end
            endcase
        end
    end

    // Payload is forced to zero outside BUSY so idle lines do not toggle.
    assign bus.mem_en    = busy;
    assign bus.mem_wr    = busy & bus.req_wr[gnt];
    assign bus.mem_addr  = busy ? bus.req_addr[int'(gnt)*ADDRW +: ADDRW] : '0;
    assign bus.mem_wdata = busy ? bus.req_wdata[int'(gnt)*XLEN +: XLEN] : '0;
    assign bus.mem_strb  = busy ? bus.req_strb[int'(gnt)*SW +: SW] : '0;
    assign bus.arb_grant = busy ? gnt_oh : '0;
    assign bus.req_ready = done ? gnt_oh : '0;
    assign bus.req_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_friscv_mem_arbiter.sv
// Bench for friscv_mem_arbiter: a 4-channel round-robin and a 2-channel fixed-priority instance
// driven by one process, with a per-instance completion scoreboard and a latency-programmable memory.
module tb_friscv_mem_arbiter;
    logic aclk;
    logic aresetn;
    logic srst;

    friscv_mem_arbiter_if #(.NB_CH(4), .ADDRW(16), .XLEN(32)) rr_if ();
    friscv_mem_arbiter_if #(.NB_CH(2), .ADDRW(16), .XLEN(32)) fp_if ();

    friscv_mem_arbiter #(.NB_CH(4), .ADDRW(16), .XLEN(32), .FIXED_PRIO(0)) u_rr (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(rr_if.slave)
    );
    friscv_mem_arbiter #(.NB_CH(2), .ADDRW(16), .XLEN(32), .FIXED_PRIO(1)) u_fp (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .bus(fp_if.slave)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int          ch;
        logic [31:0] data;
    } exp_t;

    exp_t rr_q[$];
    exp_t fp_q[$];
    int   rr_left[4];
    int   fp_left[2];
    int   rr_lat, fp_lat, rr_cnt, fp_cnt;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [15:0] a);
        return (a == 16'h0040) ? 32'hDEADBEEF : {a, ~a};
    endfunction

    function automatic exp_t mk(input int ch, input logic [15:0] a);
        exp_t e;
        e.ch   = ch;
        e.data = mem_data(a);
        return e;
    endfunction

    task automatic rr_start(input int ch, input int n, input logic wr, input logic [15:0] a,
                            input logic [31:0] wd, input logic [3:0] st);
        rr_if.req_wr[ch]            = wr;
        rr_if.req_addr[ch*16 +: 16] = a;
        rr_if.req_wdata[ch*32 +: 32] = wd;
        rr_if.req_strb[ch*4 +: 4]   = st;
        rr_left[ch]                 = n;
        rr_if.req_en[ch]            = 1'b1;
    endtask

    task automatic fp_start(input int ch, input int n, input logic wr, input logic [15:0] a,
                            input logic [31:0] wd, input logic [3:0] st);
        fp_if.req_wr[ch]            = wr;
        fp_if.req_addr[ch*16 +: 16] = a;
        fp_if.req_wdata[ch*32 +: 32] = wd;
        fp_if.req_strb[ch*4 +: 4]   = st;
        fp_left[ch]                 = n;
        fp_if.req_en[ch]            = 1'b1;
    endtask

    task automatic mem_step();
        if (rr_if.mem_ready) rr_cnt = 0;
        if (rr_if.mem_en) begin
            rr_if.mem_ready = (rr_cnt >= rr_lat);
            rr_cnt++;
        end else begin
            rr_if.mem_ready = 1'b0;
            rr_cnt = 0;
        end
        rr_if.mem_rdata = mem_data(rr_if.mem_addr);
        if (fp_if.mem_ready) fp_cnt = 0;
        if (fp_if.mem_en) begin
            fp_if.mem_ready = (fp_cnt >= fp_lat);
            fp_cnt++;
        end else begin
            fp_if.mem_ready = 1'b0;
            fp_cnt = 0;
        end
        fp_if.mem_rdata = mem_data(fp_if.mem_addr);
    endtask

    task automatic monitor();
        exp_t e;
        for (int ch = 0; ch < 4; ch++) begin
            if (rr_if.req_ready[ch]) begin
                if (rr_q.size() == 0) check("rr_spurious_ready", rr_if.req_ready, 0);
                else begin
                    e = rr_q.pop_front();
                    check("rr_ready_ch", ch, e.ch);
                    check("rr_rdata", rr_if.req_rdata, e.data);
                end
                if (rr_left[ch] > 0) begin
                    rr_left[ch]--;
                    if (rr_left[ch] == 0) rr_if.req_en[ch] = 1'b0;
                end
            end
        end
        if (rr_if.req_ready != 0) check("rr_ready_in_grant", rr_if.req_ready & ~rr_if.arb_grant, 0);
        for (int ch = 0; ch < 2; ch++) begin
            if (fp_if.req_ready[ch]) begin
                if (fp_q.size() == 0) check("fp_spurious_ready", fp_if.req_ready, 0);
                else begin
                    e = fp_q.pop_front();
                    check("fp_ready_ch", ch, e.ch);
                    check("fp_rdata", fp_if.req_rdata, e.data);
                end
                if (fp_left[ch] > 0) begin
                    fp_left[ch]--;
                    if (fp_left[ch] == 0) fp_if.req_en[ch] = 1'b0;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        mem_step();
        @(negedge aclk);
        monitor();
    endtask

    function automatic bit pending();
        int s = 0;
        for (int i = 0; i < 4; i++) s += rr_left[i];
        for (int i = 0; i < 2; i++) s += fp_left[i];
        return (s != 0) || (rr_q.size() != 0) || (fp_q.size() != 0);
    endfunction

    task automatic run_done(input int budget, output int cyc);
        cyc = 0;
        while (pending() && cyc < budget) begin
            tick();
            cyc++;
        end
        check("drain_rr_queue", rr_q.size(), 0);
        check("drain_fp_queue", fp_q.size(), 0);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_en"}, {rr_if.mem_en, fp_if.mem_en}, 0);
        check({tag, "_req_ready"}, {rr_if.req_ready, fp_if.req_ready}, 0);
        check({tag, "_arb_grant"}, {rr_if.arb_grant, fp_if.arb_grant}, 0);
        check({tag, "_mem_wr"}, {rr_if.mem_wr, fp_if.mem_wr}, 0);
        check({tag, "_mem_addr"}, {rr_if.mem_addr, fp_if.mem_addr}, 0);
        check({tag, "_mem_wdata"}, {rr_if.mem_wdata, fp_if.mem_wdata}, 0);
        check({tag, "_mem_strb"}, {rr_if.mem_strb, fp_if.mem_strb}, 0);
    endtask

    initial begin
        int cyc;
        int en_hi;
        int en_lo;

        aresetn = 1'b0;
        srst    = 1'b0;
        rr_if.req_en = '0; rr_if.req_wr = '0; rr_if.req_addr = '0; rr_if.req_wdata = '0;
        rr_if.req_strb = '0; rr_if.mem_rdata = '0; rr_if.mem_ready = 1'b0;
        fp_if.req_en = '0; fp_if.req_wr = '0; fp_if.req_addr = '0; fp_if.req_wdata = '0;
        fp_if.req_strb = '0; fp_if.mem_rdata = '0; fp_if.mem_ready = 1'b0;
        rr_lat = 0; fp_lat = 0; rr_cnt = 0; fp_cnt = 0;
        for (int i = 0; i < 4; i++) rr_left[i] = 0;
        for (int i = 0; i < 2; i++) fp_left[i] = 0;

        // Reset state and quiet idle after release
        repeat (3) tick();
        check_zero("reset");
        aresetn = 1'b1;
        en_hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rr_if.mem_en || fp_if.mem_en) en_hi++;
        end
        check("idle_mem_en_cycles", en_hi, 0);

        // Single read on ch1 with 3 wait cycles
        rr_lat = 3;
        rr_q.push_back(mk(1, 16'h0040));
        rr_start(1, 1, 1'b0, 16'h0040, 32'h0, 4'h0);
        tick();
        check("rd_mem_en", rr_if.mem_en, 1);
        check("rd_mem_addr", rr_if.mem_addr, 16'h0040);
        check("rd_arb_grant", rr_if.arb_grant, 4'b0010);
        check("rd_mem_wr", rr_if.mem_wr, 0);
        run_done(50, cyc);
        check("rd_wait_cycles", cyc, 3);
        tick();
        check("rd_back_to_idle", rr_if.mem_en, 0);

        // Asynchronous reset in the middle of an access
        rr_lat = 20;
        rr_start(2, 1, 1'b0, 16'h0080, 32'h0, 4'h0);
        tick();
        tick();
        check("ar_busy_before", rr_if.mem_en, 1);
        @(posedge aclk);
        #3;
        aresetn = 1'b0;
        #1;
        check_zero("async_rst");
        rr_if.req_en = '0;
        for (int i = 0; i < 4; i++) rr_left[i] = 0;
        @(negedge aclk);
        tick();
        aresetn = 1'b1;
        en_hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rr_if.mem_en || fp_if.mem_en) en_hi++;
        end
        check("post_arst_idle_cycles", en_hi, 0);

        // Round-robin, all four channels continuously requesting, zero memory latency
        rr_lat = 0;
        for (int r = 0; r < 2; r++)
            for (int ch = 0; ch < 4; ch++) rr_q.push_back(mk(ch, 16'(16'h1000 + ch)));
        for (int ch = 0; ch < 4; ch++) rr_start(ch, 2, 1'b0, 16'(16'h1000 + ch), 32'h0, 4'h0);
        en_lo = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (!rr_if.mem_en) en_lo++;
        end
        check("rr_mem_en_gaps", en_lo, 0);
        run_done(20, cyc);

        // Fixed priority: ch0 reads, ch1 writes, expected alternation 0,1,0,1
        fp_lat = 0;
        for (int r = 0; r < 2; r++) begin
            fp_q.push_back(mk(0, 16'h0100));
            fp_q.push_back(mk(1, 16'h0200));
        end
        fp_start(0, 2, 1'b0, 16'h0100, 32'h0, 4'h0);
        fp_start(1, 2, 1'b1, 16'h0200, 32'h12345678, 4'hF);
        cyc = 0;
        while (pending() && cyc < 30) begin
            tick();
            cyc++;
            if (fp_if.arb_grant == 2'b10) begin
                check("fp_wr_mem_wr", fp_if.mem_wr, 1);
                check("fp_wr_wdata", fp_if.mem_wdata, 32'h12345678);
                check("fp_wr_strb", fp_if.mem_strb, 4'hF);
                check("fp_wr_addr", fp_if.mem_addr, 16'h0200);
            end
        end
        run_done(5, cyc);

        // Completion of ch0 coincides with ch1 raising req_en
        rr_lat = 2;
        rr_q.push_back(mk(0, 16'h0300));
        rr_start(0, 1, 1'b0, 16'h0300, 32'h0, 4'h0);
        cyc = 0;
        while (rr_left[0] != 0 && cyc < 50) begin
            tick();
            cyc++;
        end
        check("sim_ch0_done", rr_left[0], 0);
        rr_q.push_back(mk(1, 16'h0310));
        rr_start(1, 1, 1'b0, 16'h0310, 32'h0, 4'h0);
        tick();
        check("sim_grant_ch1", rr_if.arb_grant, 4'b0010);
        check("sim_mem_en", rr_if.mem_en, 1);
        check("sim_no_early_ready", rr_if.req_ready, 0);
        run_done(50, cyc);

        // Synchronous reset while waiting on memory, then round-robin restarts at ch0
        rr_lat = 20;
        rr_start(2, 1, 1'b0, 16'h0400, 32'h0, 4'h0);
        tick();
        check("srst_busy_before", rr_if.mem_en, 1);
        srst = 1'b1;
        tick();
        check_zero("srst");
        srst = 1'b0;
        rr_if.req_en[2] = 1'b0;
        rr_left[2] = 0;
        rr_lat = 0;
        rr_q.push_back(mk(0, 16'h0500));
        rr_q.push_back(mk(3, 16'h0530));
        rr_start(3, 1, 1'b0, 16'h0530, 32'h0, 4'h0);
        rr_start(0, 1, 1'b0, 16'h0500, 32'h0, 4'h0);
        run_done(20, cyc);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
